// File: rtl/lsu_ctrl_if.sv
// Request/response handshake and word-memory port bundle for lsu_ctrl.
// master = requester plus memory side, slave = lsu_ctrl.
interface lsu_ctrl_if #(
    parameter int unsigned MEM_AW = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word accesses over a single-port word memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses via rsp_err.
module lsu_ctrl #(
    parameter int unsigned MEM_AW = 6
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
    state_t state, state_nx;

    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [MEM_AW+1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [31:0]       wword_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              misalign;
    logic              word_store;
    logic              ready_c;
    logic              re_c;
    logic              we_c;
    logic              rsp_c;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:MEM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign accept     = bus.req_valid && ready_c;
    assign word_store = bus.req_we && bus.req_size[1];

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                          input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (lane)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (lane[1]) begin
            r[31:16] = d;
        end else begin
            r[15:0] = d;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        re_c     = 1'b0;
        we_c     = 1'b0;
        rsp_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (misalign)        state_nx = DONE;
                    else if (word_store) state_nx = WRITE;
                    else                 state_nx = READ;
                end
            end
            READ: begin
                re_c     = 1'b1;
                state_nx = WAIT;
            end
            WAIT:  state_nx = we_q ? WRITE : DONE;
            WRITE: begin
                we_c     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                rsp_c    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sub-word stores read-modify-write: WAIT merges the fetched word into wword_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q    <= bus.req_we;
                    uns_q   <= bus.req_unsigned;
                    size_q  <= bus.req_size;
                    addr_q  <= bus.req_addr[MEM_AW+1:0];
                    wdata_q <= bus.req_wdata[15:0];
                    if (word_store) wword_q <= bus.req_wdata;
                    if (misalign)   rdata_q <= '0;
                end
                WAIT: begin
                    if (we_q) wword_q <= merge(bus.mem_rdata, wdata_q, size_q, addr_q[1:0]);
                    else      rdata_q <= extract(bus.mem_rdata, size_q, addr_q[1:0], uns_q);
                end
                WRITE:   rdata_q <= '0;
                default: ;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        err_q <= 1'b0;
        else if (accept) err_q <= misalign;
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = ready_c;
    assign bus.mem_re    = re_c;
    assign bus.mem_we    = we_c;
    assign bus.rsp_valid = rsp_c;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_addr  = addr_q[MEM_AW+1:2];
    assign bus.mem_wdata = wword_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus random traffic checked
// against an arithmetic reference model and a shadow copy of memory.
module tb_lsu_ctrl;
    localparam int unsigned MEM_AW = 6;
    localparam int unsigned DEPTH  = 1 << MEM_AW;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    lsu_ctrl_if #(.MEM_AW(MEM_AW)) bus ();
    lsu_ctrl #(.MEM_AW(MEM_AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ref_mem [DEPTH];
    logic              pl_we;
    logic [MEM_AW-1:0] pl_addr;
    logic [31:0]       pl_data;

    always @(posedge clk) begin
        if (pl_we)      mem[pl_addr] <= pl_data;
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int checks = 0;
    int passes = 0;

    int                exp_lat, exp_we_k;
    logic [31:0]       exp_rdata, exp_wdata;
    logic              exp_err, exp_re, exp_we;
    logic [MEM_AW-1:0] exp_idx;

    int                obs_lat, obs_re_cnt, obs_we_cnt, obs_we_k, obs_ready_hi;
    logic [31:0]       obs_rdata, obs_wdata;
    logic              obs_err, obs_both;
    logic [MEM_AW-1:0] obs_re_addr, obs_waddr;

    task automatic poke(input int unsigned idx, input logic [31:0] data);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = idx[MEM_AW-1:0];
        pl_data = data;
        ref_mem[idx] = data;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic predict(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input bit commit);
        int unsigned idx, off, sh;
        logic [31:0] word, mask, v;
        idx       = (addr / 4) % DEPTH;
        off       = addr % 4;
        exp_idx   = idx[MEM_AW-1:0];
        exp_re    = 1'b0;
        exp_we    = 1'b0;
        exp_we_k  = 0;
        exp_rdata = '0;
        exp_wdata = '0;
        exp_err   = 1'b0;
        if (TRAP && ((sz == 2'd1 && off % 2 == 1) || (sz >= 2'd2 && off != 0))) begin
            exp_lat = 1;
            exp_err = 1'b1;
            return;
        end
        word = ref_mem[idx];
        sh   = (sz == 2'd0) ? off * 8 : (sz == 2'd1 && off >= 2) ? 16 : 0;
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            exp_re  = 1'b1;
            exp_lat = 3;
            v = (word >> sh) & mask;
            if (sz < 2'd2 && !uns && v > (mask >> 1)) v = v - (mask + 1);
            exp_rdata = v;
        end else begin
            exp_we    = 1'b1;
            exp_wdata = (word & ~(mask << sh)) | ((wd & mask) << sh);
            if (sz >= 2'd2) begin
                exp_lat  = 2;
                exp_we_k = 1;
            end else begin
                exp_re   = 1'b1;
                exp_lat  = 4;
                exp_we_k = 3;
            end
            if (commit) ref_mem[idx] = exp_wdata;
        end
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
    endtask

    // Index k counts cycles after the acceptance edge; sampled mid-cycle.
    task automatic observe(input bit hold);
        #1;
        if (!hold) bus.req_valid = 1'b0;
        obs_lat = -1; obs_re_cnt = 0; obs_we_cnt = 0; obs_we_k = 0; obs_ready_hi = 0;
        obs_rdata = 'x; obs_err = 1'bx; obs_both = 1'b0; obs_wdata = 'x;
        obs_re_addr = 'x; obs_waddr = 'x;
        for (int k = 1; k <= 8 && obs_lat < 0; k++) begin
            @(negedge clk);
            if (bus.req_ready) obs_ready_hi++;
            if (bus.mem_re) begin
                obs_re_cnt++;
                obs_re_addr = bus.mem_addr;
            end
            if (bus.mem_we) begin
                obs_we_cnt++;
                obs_we_k  = k;
                obs_waddr = bus.mem_addr;
                obs_wdata = bus.mem_wdata;
            end
            if (bus.mem_re && bus.mem_we) obs_both = 1'b1;
            if (bus.rsp_valid) begin
                obs_lat   = k;
                obs_rdata = bus.rsp_rdata;
                obs_err   = bus.rsp_err;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        pl_we = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); else passes++;
        checks++; if (bus.rsp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", bus.rsp_rdata); else passes++;
        checks++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.rsp_err); else passes++;
        checks++; if (bus.mem_re !== 1'b0) $display("FAIL rst_mem_re got %b want 0", bus.mem_re); else passes++;
        checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we got %b want 0", bus.mem_we); else passes++;
        checks++; if (bus.mem_addr !== '0) $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); else passes++;
        checks++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); else passes++;
        rst = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) poke(i, $urandom);
        poke(1, 32'h8000_00F4);
        poke(2, 32'h1122_3344);
    endtask

    task automatic test_loads;
        predict(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 1'b1);
        send(1'b0, 2'b00, 1'b0, 32'h4, 32'h0); observe(1'b0);
        checks++; if (obs_lat !== 3) $display("FAIL lb_latency got %0d want 3", obs_lat); else passes++;
        checks++; if (obs_rdata !== 32'hFFFF_FFF4) $display("FAIL lb_rdata got %h want FFFFFFF4", obs_rdata); else passes++;
        checks++; if (obs_re_addr !== 6'd1) $display("FAIL lb_mem_addr got %0d want 1", obs_re_addr); else passes++;
        send(1'b0, 2'b00, 1'b1, 32'h4, 32'h0); observe(1'b0);
        checks++; if (obs_rdata !== 32'h0000_00F4) $display("FAIL lbu_rdata got %h want 000000F4", obs_rdata); else passes++;
        @(negedge clk);
        checks++; if (bus.rsp_rdata !== 32'h0000_00F4) $display("FAIL rdata_hold got %h want 000000F4", bus.rsp_rdata); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rsp_pulse got %b want 0", bus.rsp_valid); else passes++;
        send(1'b0, 2'b01, 1'b0, 32'h6, 32'h0); observe(1'b0);
        checks++; if (obs_rdata !== 32'hFFFF_8000) $display("FAIL lh_rdata got %h want FFFF8000", obs_rdata); else passes++;
        checks++; if (obs_lat !== 3) $display("FAIL lh_latency got %0d want 3", obs_lat); else passes++;
    endtask

    task automatic test_subword_stores;
        predict(1'b1, 2'b00, 1'b0, 32'h9, 32'hAB, 1'b1);
        send(1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFF_FFAB); observe(1'b0);
        checks++; if (obs_we_k !== 3) $display("FAIL sb_we_cycle got %0d want 3", obs_we_k); else passes++;
        checks++; if (obs_wdata !== 32'h1122_AB44) $display("FAIL sb_wdata got %h want 1122AB44", obs_wdata); else passes++;
        checks++; if (obs_lat !== 4) $display("FAIL sb_latency got %0d want 4", obs_lat); else passes++;
        checks++; if (obs_rdata !== 32'h0) $display("FAIL sb_rdata got %h want 0", obs_rdata); else passes++;
        poke(2, 32'h1122_3344);
        send(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234_BEEF); observe(1'b0);
        ref_mem[2] = 32'hBEEF_3344;
        checks++; if (obs_wdata !== 32'hBEEF_3344) $display("FAIL sh_wdata got %h want BEEF3344", obs_wdata); else passes++;
        checks++; if (obs_waddr !== 6'd2) $display("FAIL sh_mem_addr got %0d want 2", obs_waddr); else passes++;
    endtask

    task automatic test_word_store_wrap;
        predict(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1);
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF); observe(1'b0);
        checks++; if (obs_waddr !== 6'd0) $display("FAIL sw_mem_addr got %0d want 0", obs_waddr); else passes++;
        checks++; if (obs_we_k !== 1) $display("FAIL sw_we_cycle got %0d want 1", obs_we_k); else passes++;
        checks++; if (obs_lat !== 2) $display("FAIL sw_latency got %0d want 2", obs_lat); else passes++;
        checks++; if (obs_re_cnt !== 0) $display("FAIL sw_no_read got %0d want 0", obs_re_cnt); else passes++;
        checks++; if (obs_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got %h want DEADBEEF", obs_wdata); else passes++;
    endtask

    task automatic test_back_to_back;
        predict(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h4, 32'h0); observe(1'b1);
        checks++; if (obs_ready_hi !== 0) $display("FAIL b2b_ready_busy got %0d high cycles want 0", obs_ready_hi); else passes++;
        checks++; if (obs_rdata !== exp_rdata) $display("FAIL b2b_first_rdata got %h want %h", obs_rdata, exp_rdata); else passes++;
        bus.req_addr = 32'h8;
        predict(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_accept_t4 got %b want 1", bus.req_ready); else passes++;
        @(posedge clk);
        observe(1'b0);
        checks++; if (obs_lat !== 3) $display("FAIL b2b_second_latency got %0d want 3", obs_lat); else passes++;
        checks++; if (obs_rdata !== exp_rdata) $display("FAIL b2b_second_rdata got %h want %h", obs_rdata, exp_rdata); else passes++;
    endtask

    task automatic test_reset_mid_op;
        int we_seen, rsp_seen;
        send(1'b1, 2'b00, 1'b0, 32'h9, 32'h55);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", bus.req_ready); else passes++;
        checks++; if (bus.rsp_rdata !== 32'h0) $display("FAIL midrst_rdata got %h want 0", bus.rsp_rdata); else passes++;
        we_seen = 0; rsp_seen = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (bus.mem_we) we_seen++;
            if (bus.rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        checks++; if (we_seen !== 0) $display("FAIL midrst_no_we got %0d want 0", we_seen); else passes++;
        checks++; if (rsp_seen !== 0) $display("FAIL midrst_no_rsp got %0d want 0", rsp_seen); else passes++;
        predict(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h8, 32'h0); observe(1'b0);
        checks++; if (obs_rdata !== exp_rdata) $display("FAIL midrst_word_kept got %h want %h", obs_rdata, exp_rdata); else passes++;
    endtask

    task automatic test_misalign;
        predict(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h6, 32'h0); observe(1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (obs_lat !== 1) $display("FAIL mis_latency got %0d want 1", obs_lat); else passes++;
        checks++; if (obs_err !== 1'b1) $display("FAIL mis_err got %b want 1", obs_err); else passes++;
        checks++; if (obs_re_cnt !== 0) $display("FAIL mis_no_read got %0d want 0", obs_re_cnt); else passes++;
        checks++; if (obs_rdata !== 32'h0) $display("FAIL mis_rdata got %h want 0", obs_rdata); else passes++;
`else
        checks++; if (obs_lat !== 3) $display("FAIL mis_latency got %0d want 3", obs_lat); else passes++;
        checks++; if (obs_err !== 1'b0) $display("FAIL mis_err got %b want 0", obs_err); else passes++;
        checks++; if (obs_re_addr !== 6'd1) $display("FAIL mis_mem_addr got %0d want 1", obs_re_addr); else passes++;
        checks++; if (obs_rdata !== 32'h8000_00F4) $display("FAIL mis_rdata got %h want 800000F4", obs_rdata); else passes++;
`endif
    endtask

    task automatic test_random;
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] addr, wd;
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = $urandom;
            wd   = $urandom;
            predict(we, sz, uns, addr, wd, 1'b1);
            send(we, sz, uns, addr, wd); observe(1'b0);
            checks++; if (obs_lat !== exp_lat) $display("FAIL rnd%0d_latency got %0d want %0d", i, obs_lat, exp_lat); else passes++;
            checks++; if (obs_rdata !== exp_rdata) $display("FAIL rnd%0d_rdata got %h want %h", i, obs_rdata, exp_rdata); else passes++;
            checks++; if (obs_err !== exp_err) $display("FAIL rnd%0d_err got %b want %b", i, obs_err, exp_err); else passes++;
            checks++; if (obs_re_cnt !== int'(exp_re)) $display("FAIL rnd%0d_reads got %0d want %0d", i, obs_re_cnt, exp_re); else passes++;
            checks++; if (obs_we_cnt !== int'(exp_we)) $display("FAIL rnd%0d_writes got %0d want %0d", i, obs_we_cnt, exp_we); else passes++;
            checks++; if (obs_both !== 1'b0) $display("FAIL rnd%0d_re_we_overlap got %b want 0", i, obs_both); else passes++;
            checks++; if (obs_ready_hi !== 0) $display("FAIL rnd%0d_ready_busy got %0d want 0", i, obs_ready_hi); else passes++;
            if (exp_re) begin
                checks++; if (obs_re_addr !== exp_idx) $display("FAIL rnd%0d_read_addr got %0d want %0d", i, obs_re_addr, exp_idx); else passes++;
            end
            if (exp_we) begin
                checks++; if (obs_wdata !== exp_wdata) $display("FAIL rnd%0d_wdata got %h want %h", i, obs_wdata, exp_wdata); else passes++;
                checks++; if (obs_waddr !== exp_idx) $display("FAIL rnd%0d_write_addr got %0d want %0d", i, obs_waddr, exp_idx); else passes++;
                checks++; if (obs_we_k !== exp_we_k) $display("FAIL rnd%0d_we_cycle got %0d want %0d", i, obs_we_k, exp_we_k); else passes++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_loads();
        test_subword_stores();
        test_word_store_wrap();
        test_back_to_back();
        test_reset_mid_op();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
